mips_mem_arbiter: RTL and testbench

- Shares one single-ported memory bus between the instruction-fetch and data ports of mips_cpu_harvard.
- Sequences each CPU cycle as fetch, then an optional data access, then commit.
- Gates the CPU through clk_enable so that the CPU advances only when all of its accesses for that cycle have completed.
- Sits between the CPU and the memory/bus model in the harvard system and testbenches; it replaces the ideal combinational ROM/RAM.

---
 rtl/mips_mem_arb_pkg.sv | 14 +
 rtl/mips_mem_arb_timeout.sv | 28 ++
 rtl/mips_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mips_mem_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_arb_pkg.sv
// Shared types and constants for the MIPS instruction/data memory arbiter.
package mips_mem_arb_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    DATA   = 2'd2,
    COMMIT = 2'd3
  } arb_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
  localparam int          CNT_W            = 32;

endpackage

// File: rtl/mips_mem_arb_timeout.sv
// Counts consecutive bus wait cycles and flags the cycle on which the limit is hit.
module mips_mem_arb_timeout #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic limit_reached
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= count + 1'b1;
  end

  // High during the LIMIT-th consecutive wait cycle, so the access is abandoned at that edge.
  assign limit_reached = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/mips_mem_arbiter.sv
// Serialises CPU fetch and data accesses onto one memory bus and gates the CPU
// through clk_enable until each instruction's accesses are complete.
module mips_mem_arbiter
  import mips_mem_arb_pkg::*;
#(
  parameter int          WAIT_LIMIT = 16,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        bus_error,
  output logic [31:0] commit_count,
  output logic [31:0] stall_count
);

  arb_state_t  state;
  logic        busy;
  logic        waiting;
  logic        timed_out;
  logic        done;
  logic [31:0] rd_value;

  assign busy     = mem_read | mem_write;
  assign waiting  = busy & mem_waitrequest;
  assign done     = busy & (~mem_waitrequest | timed_out);
  assign rd_value = timed_out ? ERR_DATA : mem_readdata;

  // Addresses and store data follow the live CPU ports, which stay stable while clk_enable is low.
  assign mem_address   = !busy ? '0 : ((state == FETCH) ? instr_address : data_address);
  assign mem_writedata = mem_write ? data_writedata : '0;

  mips_mem_arb_timeout #(
    .LIMIT(WAIT_LIMIT)
  ) u_timeout (
    .clk          (clk),
    .reset        (reset),
    .clear        (done),
    .enable       (waiting),
    .limit_reached(timed_out)
  );

  // The strobes are registered and raised on entry to an access state; the first
  // FETCH after reset spends one idle cycle raising mem_read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= FETCH;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      clk_enable     <= 1'b0;
      bus_error      <= 1'b0;
      instr_readdata <= '0;
      data_readdata  <= '0;
    end else begin
      if (timed_out)
        bus_error <= 1'b1;
      unique case (state)
        FETCH: begin
          if (!busy) begin
            mem_read <= 1'b1;
          end else if (done) begin
            instr_readdata <= rd_value;
            mem_read       <= 1'b0;
            state          <= DECODE;
          end
        end
        DECODE: begin
          if (data_write) begin
            mem_write <= 1'b1;
            state     <= DATA;
            if (data_read)
              bus_error <= 1'b1;
          end else if (data_read) begin
            mem_read <= 1'b1;
            state    <= DATA;
          end else begin
            clk_enable <= 1'b1;
            state      <= COMMIT;
          end
        end
        DATA: begin
          if (done) begin
            if (mem_read)
              data_readdata <= rd_value;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            clk_enable <= 1'b1;
            state      <= COMMIT;
          end
        end
        COMMIT: begin
          clk_enable <= 1'b0;
          mem_read   <= 1'b1;
          state      <= FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_count <= '0;
      stall_count  <= '0;
    end else begin
      if (state == COMMIT)
        commit_count <= commit_count + 1'b1;
      if (waiting)
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: drives the CPU side by hand and models the bus.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_address = 32'hBFC00000;
  logic [31:0] instr_readdata;
  logic [31:0] data_address = '0;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_writedata = '0;
  logic [31:0] data_readdata;
  logic        clk_enable;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        bus_error;
  logic [31:0] commit_count;
  logic [31:0] stall_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] pc = 32'hBFC00000;

  // Bus model controls: force_wait stalls forever, stall_cfg stalls the first N cycles of a strobe.
  logic        force_wait = 1'b0;
  int          stall_cfg = 0;
  int          strobe_cycles = 0;
  logic        wr_valid = 1'b0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  mips_mem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .clk_enable     (clk_enable),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .mem_waitrequest(mem_waitrequest),
    .bus_error      (bus_error),
    .commit_count   (commit_count),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_word(input logic [31:0] a);
    if (a[31:16] == 16'hBFC0)
      return 32'h00851021 + {16'h0, a[15:0]};
    else if (a == 32'h00000004)
      return 32'h12345678;
    else
      return a ^ 32'hA5A5A5A5;
  endfunction

  assign mem_waitrequest = force_wait || (strobe_cycles < stall_cfg);
  assign mem_readdata = (wr_valid && mem_address == last_wr_addr) ? last_wr_data
                                                                   : model_word(mem_address);

  always @(posedge clk) begin
    strobe_cycles <= (mem_read || mem_write) ? strobe_cycles + 1 : 0;
    if (mem_write && !mem_waitrequest) begin
      wr_valid     <= 1'b1;
      last_wr_addr <= mem_address;
      last_wr_data <= mem_writedata;
    end
  end

  task automatic advance_pc();
    pc = pc + 32'd4;
    instr_address = pc;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({clk_enable, mem_read, mem_write, bus_error} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_strobes got %b want 0000", {clk_enable, mem_read, mem_write, bus_error});
    end
    vectors++;
    if ({mem_address, mem_writedata} !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_bus got %h/%h want 0/0", mem_address, mem_writedata);
    end
    vectors++;
    if ({instr_readdata, data_readdata} !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_readdata got %h/%h want 0/0", instr_readdata, data_readdata);
    end
    vectors++;
    if ({commit_count, stall_count} !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_counters got %0d/%0d want 0/0", commit_count, stall_count);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_read !== 1'b1 || mem_address !== 32'hBFC00000) begin
      miscompares++;
      $display("[TB] FAIL first_fetch got rd=%b addr=%h want 1/bfc00000", mem_read, mem_address);
    end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) begin
        vectors++;
        if (mem_read !== 1'b1 || mem_address !== pc) begin
          miscompares++;
          $display("[TB] FAIL zw_fetch[%0d] got rd=%b addr=%h want 1/%h", i, mem_read, mem_address, pc);
        end
      end
      if (i % 3 == 1) begin
        vectors++;
        if (instr_readdata !== model_word(pc)) begin
          miscompares++;
          $display("[TB] FAIL zw_instr[%0d] got %h want %h", i, instr_readdata, model_word(pc));
        end
      end
      vectors++;
      if (clk_enable !== (i % 3 == 2)) begin
        miscompares++;
        $display("[TB] FAIL zw_clken[%0d] got %b want %b", i, clk_enable, (i % 3 == 2));
      end
      if (i % 3 == 2)
        advance_pc();
      @(negedge clk);
    end
    vectors++;
    if (commit_count !== 32'd4 || stall_count !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL zw_counts got %0d/%0d want 4/0", commit_count, stall_count);
    end
  endtask

  task automatic test_load_waits();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        data_read = 1'b1;
        data_address = 32'h00000004;
      end
      if (i == 1) begin
        vectors++;
        if (instr_readdata !== model_word(pc)) begin
          miscompares++;
          $display("[TB] FAIL lw_instr got %h want %h", instr_readdata, model_word(pc));
        end
        stall_cfg = 2;
      end
      if (i == 2) begin
        vectors++;
        if ({mem_read, mem_waitrequest, mem_address} !== {2'b11, 32'h4}) begin
          miscompares++;
          $display("[TB] FAIL lw_bus got rd=%b wt=%b addr=%h want 1/1/4", mem_read, mem_waitrequest, mem_address);
        end
      end
      vectors++;
      if (clk_enable !== (i == 5)) begin
        miscompares++;
        $display("[TB] FAIL lw_clken[%0d] got %b want %b", i, clk_enable, (i == 5));
      end
      if (i == 5) begin
        vectors++;
        if (data_readdata !== 32'h12345678) begin
          miscompares++;
          $display("[TB] FAIL lw_data got %h want 12345678", data_readdata);
        end
        vectors++;
        if (stall_count !== 32'd2) begin
          miscompares++;
          $display("[TB] FAIL lw_stalls got %0d want 2", stall_count);
        end
        data_read = 1'b0;
        stall_cfg = 0;
        advance_pc();
      end
      @(negedge clk);
    end
    vectors++;
    if (commit_count !== 32'd5) begin
      miscompares++;
      $display("[TB] FAIL lw_commits got %0d want 5", commit_count);
    end
  endtask

  task automatic test_store_then_load();
    int writes = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        data_write = 1'b1;
        data_address = 32'h00000008;
        data_writedata = 32'hCAFEF00D;
      end
      if (mem_write === 1'b1)
        writes++;
      if (i == 2) begin
        vectors++;
        if ({mem_write, mem_read, mem_address, mem_writedata} !== {2'b10, 32'h8, 32'hCAFEF00D}) begin
          miscompares++;
          $display("[TB] FAIL sw_bus got wr=%b rd=%b addr=%h data=%h want 1/0/8/cafef00d",
                   mem_write, mem_read, mem_address, mem_writedata);
        end
      end
      vectors++;
      if (clk_enable !== (i == 3)) begin
        miscompares++;
        $display("[TB] FAIL sw_clken[%0d] got %b want %b", i, clk_enable, (i == 3));
      end
      if (i == 3) begin
        data_write = 1'b0;
        advance_pc();
      end
      @(negedge clk);
    end
    vectors++;
    if (writes != 1) begin
      miscompares++;
      $display("[TB] FAIL sw_write_cycles got %0d want 1", writes);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        data_read = 1'b1;
        data_address = 32'h00000008;
      end
      if (i == 3) begin
        vectors++;
        if (clk_enable !== 1'b1 || data_readdata !== 32'hCAFEF00D) begin
          miscompares++;
          $display("[TB] FAIL sw_readback got ce=%b data=%h want 1/cafef00d", clk_enable, data_readdata);
        end
        data_read = 1'b0;
        advance_pc();
      end
      @(negedge clk);
    end
    vectors++;
    if (commit_count !== 32'd7) begin
      miscompares++;
      $display("[TB] FAIL sw_commits got %0d want 7", commit_count);
    end
  endtask

  task automatic test_conflict();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        data_read = 1'b1;
        data_write = 1'b1;
        data_address = 32'h0000000C;
        data_writedata = 32'h55AA55AA;
      end
      if (i == 1) begin
        vectors++;
        if (bus_error !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL conflict_pre_err got %b want 0", bus_error);
        end
      end
      if (i == 2) begin
        vectors++;
        if ({bus_error, mem_write, mem_read} !== 3'b110) begin
          miscompares++;
          $display("[TB] FAIL conflict_data got err/wr/rd=%b want 110", {bus_error, mem_write, mem_read});
        end
      end
      if (i == 3) begin
        vectors++;
        if (clk_enable !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL conflict_commit got ce=%b want 1", clk_enable);
        end
        data_read = 1'b0;
        data_write = 1'b0;
        advance_pc();
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    force_wait = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        vectors++;
        if (mem_read !== 1'b1 || bus_error !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL to_wait[%0d] got rd=%b err=%b want 1/0", i, mem_read, bus_error);
        end
      end
      if (i == 16) begin
        vectors++;
        if (bus_error !== 1'b1 || instr_readdata !== 32'hDEADBEEF) begin
          miscompares++;
          $display("[TB] FAIL to_abandon got err=%b instr=%h want 1/deadbeef", bus_error, instr_readdata);
        end
        vectors++;
        if (stall_count !== 32'd16) begin
          miscompares++;
          $display("[TB] FAIL to_stalls got %0d want 16", stall_count);
        end
      end
      if (i == 17) begin
        vectors++;
        if (clk_enable !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL to_commit got ce=%b want 1", clk_enable);
        end
        force_wait = 1'b0;
        advance_pc();
      end
      @(negedge clk);
    end
    vectors++;
    if (bus_error !== 1'b1 || commit_count !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL to_sticky got err=%b commits=%0d want 1/1", bus_error, commit_count);
    end
  endtask

  task automatic test_reset_mid_access();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        data_write = 1'b1;
        data_address = 32'h00000010;
        data_writedata = 32'h0BADF00D;
      end
      if (i == 1)
        stall_cfg = 50;
      if (i < 3)
        @(negedge clk);
    end
    vectors++;
    if (mem_write !== 1'b1 || mem_waitrequest !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_pre got wr=%b wt=%b want 1/1", mem_write, mem_waitrequest);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (mem_write !== 1'b0 || mem_address !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL rst_async got wr=%b addr=%h want 0/0", mem_write, mem_address);
    end
    data_write = 1'b0;
    stall_cfg = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({commit_count, stall_count} !== 64'h0 || bus_error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_counters got %0d/%0d err=%b want 0/0/0", commit_count, stall_count, bus_error);
    end
    vectors++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== pc) begin
      miscompares++;
      $display("[TB] FAIL rst_refetch got rd=%b wr=%b addr=%h want 1/0/%h", mem_read, mem_write, mem_address, pc);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_load_waits();
    test_store_then_load();
    test_conflict();
    test_timeout();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
